// File: rtl/scan_decoder_n_if.sv
// Bus for scan_decoder_n: the enables, mode and select going in, and the registered strobes coming out.
interface scan_decoder_n_if #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 2 ** SEL_W
);
  logic               G1;
  logic               G2_n;
  logic               G3_n;
  logic               mode;
  logic [SEL_W-1:0]   A;
  logic [NUM_OUT-1:0] Y;
  logic [SEL_W-1:0]   cur_sel;
  logic               wrap;

  modport master (
    output G1, G2_n, G3_n, mode, A,
    input  Y, cur_sel, wrap
  );

  modport slave (
    input  G1, G2_n, G3_n, mode, A,
    output Y, cur_sel, wrap
  );
endinterface

// File: rtl/scan_decoder_n.sv
// Registered active-low decoder with a prescaled scan mode for multiplexed display strobes.
// Define SCAN_BLANK_EN to blank Y for one cycle between scan strobes (requires DIV >= 2).
module scan_decoder_n #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 2 ** SEL_W,
  parameter int DIV     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  scan_decoder_n_if.slave bus
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef SCAN_BLANK_EN
  generate
    if (DIV < 2) begin : g_div_check
      $error("scan_decoder_n: DIV must be >= 2 when blanking is enabled");
    end
  endgenerate
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg;
  logic [PW-1:0]      presc_reg;
  logic [SEL_W-1:0]   idx_reg;
  logic [NUM_OUT-1:0] y_reg;
  logic [SEL_W-1:0]   cur_sel_reg;
  logic               wrap_reg;

  logic               en;
  logic               tick;
  logic [SEL_W-1:0]   idx_inc;
  logic [NUM_OUT-1:0] dir_y;
  logic [NUM_OUT-1:0] cur_y;
  logic [NUM_OUT-1:0] inc_y;

  assign en      = bus.G1 & ~bus.G2_n & ~bus.G3_n;
  assign tick    = (presc_reg == PW'(DIV - 1));
  assign idx_inc = (idx_reg == SEL_W'(NUM_OUT - 1)) ? '0 : idx_reg + 1'b1;

  // Out-of-range direct selects match no line, so they decode to all ones.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_dec
      assign dir_y[gi] = ~(en && (bus.A == SEL_W'(gi)));
      assign cur_y[gi] = ~(idx_reg == SEL_W'(gi));
      assign inc_y[gi] = ~(idx_inc == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      presc_reg   <= '0;
      idx_reg     <= '0;
      y_reg       <= '1;
      cur_sel_reg <= '0;
      wrap_reg    <= 1'b0;
    end else if (!bus.mode) begin
      state_reg   <= IDLE;
      presc_reg   <= '0;
      idx_reg     <= '0;
      y_reg       <= dir_y;
      cur_sel_reg <= bus.A;
      wrap_reg    <= 1'b0;
    end else if (!en) begin
      // Pause keeps idx so the resumed strobe gets a full dwell on the same line.
      state_reg <= IDLE;
      presc_reg <= '0;
      y_reg     <= '1;
      wrap_reg  <= 1'b0;
    end else if (state_reg == IDLE) begin
      state_reg   <= RUN;
      presc_reg   <= '0;
      y_reg       <= cur_y;
      cur_sel_reg <= idx_reg;
      wrap_reg    <= 1'b0;
    end else if (tick) begin
      presc_reg   <= '0;
      idx_reg     <= idx_inc;
      y_reg       <= inc_y;
      cur_sel_reg <= idx_inc;
      wrap_reg    <= (idx_inc == '0);
    end else begin
      presc_reg <= presc_reg + 1'b1;
      wrap_reg  <= 1'b0;
`ifdef SCAN_BLANK_EN
      if (presc_reg == PW'(DIV - 2)) begin
        y_reg <= '1;
      end
`endif
    end
  end

  assign bus.Y       = y_reg;
  assign bus.cur_sel = cur_sel_reg;
  assign bus.wrap    = wrap_reg;
endmodule

// File: tb/tb_scan_decoder_n.sv
// Randomised bench for scan_decoder_n: an arithmetic scan-position model checked every cycle, plus literal spot checks.
module tb_scan_decoder_n;
`ifdef SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
  localparam int D6    = 2;
`else
  localparam bit BLANK = 1'b0;
  localparam int D6    = 1;
`endif

  typedef struct {
    bit run;
    int start;
    int k;
    int cur;
    int y;
    bit w;
  } mstate_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic g1 = 1'b0, g2n = 1'b1, g3n = 1'b1, mode_v = 1'b0;
  logic [2:0] a_v = '0;
  int checks = 0;
  int errors = 0;
  mstate_t m8, m6;

  always #5 clk = ~clk;

  scan_decoder_n_if #(.SEL_W(3), .NUM_OUT(8)) if8 ();
  scan_decoder_n_if #(.SEL_W(3), .NUM_OUT(6)) if6 ();

  assign if8.G1 = g1;   assign if8.G2_n = g2n; assign if8.G3_n = g3n;
  assign if8.mode = mode_v; assign if8.A = a_v;
  assign if6.G1 = g1;   assign if6.G2_n = g2n; assign if6.G3_n = g3n;
  assign if6.mode = mode_v; assign if6.A = a_v;

  scan_decoder_n #(.SEL_W(3), .NUM_OUT(8), .DIV(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  scan_decoder_n #(.SEL_W(3), .NUM_OUT(6), .DIV(D6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(if6));

  function automatic mstate_t rst_state(int nout);
    mstate_t r;
    r.run = 0; r.start = 0; r.k = 0; r.cur = 0; r.w = 0;
    r.y = (1 << nout) - 1;
    return r;
  endfunction

  // Scan position is start line plus elapsed run cycles divided by the dwell.
  function automatic mstate_t step(mstate_t s, bit en, bit mode, int a, int nout, int div);
    mstate_t r = s;
    int mask = (1 << nout) - 1;
    int pos, ph, idx;
    if (!mode) begin
      r.run = 0; r.start = 0; r.k = 0; r.cur = a; r.w = 0;
      r.y = (en && a < nout) ? (~(1 << a)) & mask : mask;
    end else if (!en) begin
      if (s.run) r.start = (s.start + s.k / div) % nout;
      r.run = 0; r.k = 0; r.y = mask; r.w = 0;
    end else if (!s.run) begin
      r.run = 1; r.k = 0; r.cur = s.start; r.w = 0;
      r.y = (~(1 << s.start)) & mask;
    end else begin
      r.k = s.k + 1;
      pos = r.k / div;
      ph = r.k % div;
      idx = (s.start + pos) % nout;
      r.cur = idx;
      r.y = (BLANK && ph == div - 1) ? mask : (~(1 << idx)) & mask;
      r.w = (ph == 0) && (idx == 0);
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8 <= rst_state(8);
      m6 <= rst_state(6);
    end else begin
      m8 <= step(m8, g1 & ~g2n & ~g3n, mode_v, int'(a_v), 8, 4);
      m6 <= step(m6, g1 & ~g2n & ~g3n, mode_v, int'(a_v), 6, D6);
    end
  end

  always @(negedge clk) begin
    chk("y8", int'(if8.Y), m8.y);
    chk("sel8", int'(if8.cur_sel), m8.cur);
    chk("wrap8", int'(if8.wrap), int'(m8.w));
    chk("y6", int'(if6.Y), m6.y);
    chk("sel6", int'(if6.cur_sel), m6.cur);
    chk("wrap6", int'(if6.wrap), int'(m6.w));
  end

  initial begin
    int exp_y;
    repeat (3) @(negedge clk);
    chk("rst_y", int'(if8.Y), 8'hFF);
    chk("rst_sel", int'(if8.cur_sel), 0);
    #1 rst_n = 1'b1;

    // Direct decode
    g1 = 1; g2n = 0; g3n = 0; a_v = 3'd5;
    @(negedge clk);
    chk("dir_a5", int'(if8.Y), 8'hDF);
    chk("dir_sel5", int'(if8.cur_sel), 5);
    #1 g2n = 1;
    @(negedge clk);
    chk("dir_dis", int'(if8.Y), 8'hFF);
    #1 g2n = 0; a_v = 3'd7;
    @(negedge clk);
    chk("dir_a7", int'(if8.Y), 8'h7F);
    chk("oor_y6", int'(if6.Y), 6'h3F);
    chk("oor_sel6", int'(if6.cur_sel), 7);

    // Scan sweep: two full rotations
    #1 mode_v = 1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      exp_y = (BLANK && (c % 4) == 3) ? 8'hFF : (~(1 << ((c / 4) % 8))) & 8'hFF;
      chk("scan_y", int'(if8.Y), exp_y);
      chk("scan_wrap", int'(if8.wrap), (c == 32) ? 1 : 0);
    end
    repeat (9) @(negedge clk);
    chk("at_idx2", int'(if8.Y), 8'hFB);

    // Pause on line 2, then resume
    #1 g1 = 0;
    @(negedge clk);
    chk("pause_y", int'(if8.Y), 8'hFF);
    chk("pause_sel", int'(if8.cur_sel), 2);
    #1 g1 = 1;
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      exp_y = (r < 3) ? 8'hFB : (r == 3) ? (BLANK ? 8'hFF : 8'hFB) : 8'hF7;
      chk("resume_y", int'(if8.Y), exp_y);
    end

    // Asynchronous reset between edges
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y", int'(if8.Y), 8'hFF);
    chk("arst_sel", int'(if8.cur_sel), 0);
    chk("arst_wrap", int'(if8.wrap), 0);
    chk("arst_y6", int'(if6.Y), 6'h3F);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      g1  = ($urandom_range(0, 15) != 0);
      g2n = ($urandom_range(0, 19) == 0);
      g3n = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 59) == 0) mode_v = ~mode_v;
      a_v = 3'($urandom_range(0, 7));
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
